// File: rtl/snes_pad_reader.sv
// SNES/NES controller poller: drives a shared latch/clock to NUM_PADS pads and
// captures each serial word into buttons, flagging per-pad changes.
module snes_pad_reader #(
   parameter int NUM_PADS   = 2,
   parameter int NUM_BITS   = 16,
   parameter int LATCH_CYC  = 600,
   parameter int HALF_CYC   = 300,
   parameter int POLL_GAP   = 833333,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         auto_poll,
   input  logic [NUM_PADS-1:0]          data,
   output logic                         latch,
   output logic                         clock,
   output logic                         idle,
   output logic                         finish,
   output logic [NUM_PADS*NUM_BITS-1:0] buttons,
   output logic [NUM_PADS-1:0]          changed
);

   localparam int MAX_DWELL = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
   localparam int CW        = $clog2(MAX_DWELL);
   localparam int BW        = $clog2(NUM_BITS);
   localparam int GW        = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   localparam logic [CW-1:0] LATCH_END = CW'(LATCH_CYC - 1);
   localparam logic [CW-1:0] HALF_END  = CW'(HALF_CYC - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);
   localparam logic [GW-1:0] GAP_END   = GW'(POLL_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_SETUP, S_LOW, S_HIGH, S_TAIL, S_DONE
   } state_t;

   state_t                       state;
   logic [CW-1:0]                dwell;
   logic [BW-1:0]                bit_idx;
   logic [GW-1:0]                gap;
   logic [NUM_PADS-1:0]          sync_a;
   logic [NUM_PADS-1:0]          sync_b;
   logic [NUM_PADS-1:0]          sample;
   logic [NUM_PADS*NUM_BITS-1:0] shift;
   logic [NUM_PADS*NUM_BITS-1:0] shifted;
   logic [NUM_PADS-1:0]          diff;
   logic                         gap_hit;

   // New bits enter at the MSB so the first bit read ends up at bit 0.
   always_comb begin
      sample  = (ACTIVE_LOW != 0) ? ~sync_b : sync_b;
      shifted = '0;
      diff    = '0;
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
         shifted[p*NUM_BITS +: NUM_BITS] = {sample[p], shift[p*NUM_BITS+1 +: NUM_BITS-1]};
         diff[p] = (shift[p*NUM_BITS +: NUM_BITS] != buttons[p*NUM_BITS +: NUM_BITS]);
      end
      gap_hit = auto_poll && (gap == GAP_END);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         dwell   <= '0;
         bit_idx <= '0;
         gap     <= '0;
         sync_a  <= '0;
         sync_b  <= '0;
         shift   <= '0;
         buttons <= '0;
         changed <= '0;
         latch   <= 1'b0;
         clock   <= 1'b1;
         idle    <= 1'b1;
         finish  <= 1'b0;
      end else begin
         sync_a  <= data;
         sync_b  <= sync_a;
         finish  <= 1'b0;
         changed <= '0;
         case (state)
            S_IDLE: begin
               if (start || gap_hit) begin
                  state <= S_LATCH;
                  latch <= 1'b1;
                  idle  <= 1'b0;
                  gap   <= '0;
               end else if (auto_poll) begin
                  gap <= gap + 1'b1;
               end else begin
                  gap <= '0;
               end
            end
            S_LATCH: begin
               if (dwell == LATCH_END) begin
                  dwell <= '0;
                  latch <= 1'b0;
                  state <= S_SETUP;
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            S_SETUP, S_HIGH: begin
               if (dwell == HALF_END) begin
                  dwell <= '0;
                  shift <= shifted;
                  clock <= 1'b0;
                  state <= S_LOW;
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            S_LOW: begin
               if (dwell == HALF_END) begin
                  dwell <= '0;
                  clock <= 1'b1;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
                     state   <= S_TAIL;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     state   <= S_HIGH;
                  end
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            S_TAIL: begin
               if (dwell == LATCH_END) begin
                  dwell   <= '0;
                  buttons <= shift;
                  changed <= diff;
                  finish  <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            S_DONE: begin
               idle  <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               latch <= 1'b0;
               clock <= 1'b1;
               idle  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader: pad models, a poll-schedule reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_snes_pad_reader;

   localparam int NP    = 2;
   localparam int NB    = 16;
   localparam int LC    = 4;
   localparam int HC    = 4;
   localparam int GAP   = 50;
   localparam int T_FIN = 2*LC + 2*NB*HC;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          auto_poll = 1'b0;
   logic [NP-1:0] data;
   logic          latch, clock, idle, finish;
   logic [NP*NB-1:0] buttons;
   logic [NP-1:0] changed;

   logic [15:0] pad_word [NP];
   logic [15:0] pad_sr   [NP] = '{16'hFFFF, 16'hFFFF};

   int checks = 0;
   int errors = 0;

   snes_pad_reader #(
      .NUM_PADS(NP), .NUM_BITS(NB), .LATCH_CYC(LC), .HALF_CYC(HC),
      .POLL_GAP(GAP), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .auto_poll(auto_poll),
      .data(data), .latch(latch), .clock(clock), .idle(idle),
      .finish(finish), .buttons(buttons), .changed(changed)
   );

   always #5 clk = ~clk;

   // Pad: load on latch, present next bit after each clock rising edge.
   assign data = {pad_sr[1][0], pad_sr[0][0]};
   always @(posedge latch or posedge clock) begin
      for (int p = 0; p < NP; p++) begin
         if (latch) pad_sr[p] = pad_word[p];
         else       pad_sr[p] = {1'b1, pad_sr[p][15:1]};
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: phase = cycles since first latch cycle of the current poll, -1 when idle.
   int          phase = -1;
   int          idle_run = 0;
   logic [31:0] mbuttons = '0;
   logic [31:0] mnew;
   logic [1:0]  mchanged = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         phase = -1; idle_run = 0; mbuttons = '0; mchanged = '0;
      end else begin
         mchanged = '0;
         if (phase < 0) begin
            if (start || (auto_poll && idle_run == GAP-1)) begin
               phase = 0; idle_run = 0;
            end else if (auto_poll) idle_run++;
            else idle_run = 0;
         end else if (phase == T_FIN) begin
            phase = -1;
         end else begin
            phase++;
            if (phase == T_FIN) begin
               mnew = ~{pad_word[1], pad_word[0]};
               mchanged[0] = (mnew[15:0]  != mbuttons[15:0]);
               mchanged[1] = (mnew[31:16] != mbuttons[31:16]);
               mbuttons = mnew;
            end
         end
      end
   end

   int   cyc = 0, rise_cnt = 0, rise_cyc = 0, prev_rise_cyc = 0, fin_cyc = 0;
   int   low_cnt = 0, fin_cnt = 0, lat_hi = 0;
   logic prev_latch = 1'b0, prev_clock = 1'b1;
   logic exp_low;

   always @(negedge clk) begin
      cyc++;
      exp_low = (phase >= LC+HC) && (phase < LC + 2*NB*HC) && (((phase-LC-HC) % (2*HC)) < HC);
      check("latch",   latch,   (phase >= 0) && (phase < LC));
      check("clock",   clock,   !exp_low);
      check("idle",    idle,    phase < 0);
      check("finish",  finish,  phase == T_FIN);
      check("buttons", buttons, mbuttons);
      check("changed", changed, mchanged);
      if (latch && !prev_latch) begin
         rise_cnt++; prev_rise_cyc = rise_cyc; rise_cyc = cyc;
      end
      if (latch) lat_hi++;
      if (!clock && prev_clock) low_cnt++;
      if (finish) begin fin_cnt++; fin_cyc = cyc; end
      prev_latch = latch;
      prev_clock = clock;
   end

   task automatic tick(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(1); start = 1'b0;
   endtask

   task automatic wait_finish(input int max);
      int n = 0;
      do begin tick(1); n++; end while (!finish && n < max);
      checks++;
      if (!finish) begin errors++; $display("FAIL finish_timeout: no finish within %0d cycles", max); end
   endtask

   task automatic wait_rise(input int target, input int max);
      int n = 0;
      while (rise_cnt < target && n < max) begin tick(1); n++; end
      checks++;
      if (rise_cnt < target) begin errors++; $display("FAIL rise_timeout: got %0d rises expected %0d", rise_cnt, target); end
   endtask

   task automatic wait_low8(input int max);
      int n = 0;
      while (!(low_cnt == 8 && !clock) && n < max) begin tick(1); n++; end
      checks++;
      if (!(low_cnt == 8 && !clock)) begin errors++; $display("FAIL low8_timeout: low pulses %0d", low_cnt); end
   endtask

   int r0;

   initial begin
      pad_word[0] = 16'hFFFE;
      pad_word[1] = 16'h7FFF;
      tick(3);
      check("rst_latch", latch, 0);
      check("rst_clock", clock, 1);
      check("rst_idle", idle, 1);
      check("rst_buttons", buttons, 0);
      reset = 1'b0;
      tick(60);
      check("no_poll_after_reset", rise_cnt, 0);

      // Single poll
      low_cnt = 0;
      pulse_start();
      wait_finish(300);
      check("poll1_latency", fin_cyc - rise_cyc, 136);
      check("poll1_buttons", buttons, 32'h8000_0001);
      check("poll1_changed", changed, 2'b11);
      check("poll1_lows", low_cnt, 16);
      tick(5);

      // Repeat with identical data
      pulse_start();
      wait_finish(300);
      check("poll2_buttons", buttons, 32'h8000_0001);
      check("poll2_changed", changed, 2'b00);
      tick(5);

      // Different pattern
      pad_word[0] = 16'hA5A5;
      pad_word[1] = 16'h1234;
      pulse_start();
      wait_finish(300);
      check("poll3_buttons", buttons, 32'hEDCB_5A5A);
      check("poll3_changed", changed, 2'b11);
      tick(5);

      // Start during LOW is dropped
      fin_cnt = 0;
      pulse_start();
      tick(LC + HC + 2);
      check("busy_clock_low", clock, 0);
      pulse_start();
      tick(300);
      check("busy_start_one_finish", fin_cnt, 1);

      // Periodic polling, then stop mid-poll
      r0 = rise_cnt;
      auto_poll = 1'b1;
      wait_rise(r0 + 2, 600);
      check("auto_interval", rise_cyc - prev_rise_cyc, GAP + 136 + 1);
      wait_rise(r0 + 3, 300);
      tick(20);
      auto_poll = 1'b0;
      wait_finish(300);
      tick(250);
      check("auto_stop_rises", rise_cnt, r0 + 3);
      check("auto_stop_idle", idle, 1);

      // Reset during the 8th LOW
      low_cnt = 0;
      pulse_start();
      wait_low8(200);
      reset = 1'b1;
      #1;
      check("midrst_latch", latch, 0);
      check("midrst_clock", clock, 1);
      check("midrst_buttons", buttons, 0);
      check("midrst_idle", idle, 1);
      tick(2);
      reset = 1'b0;
      tick(3);
      pad_word[0] = 16'h0F0F;
      pad_word[1] = 16'hFFFF;
      low_cnt = 0;
      pulse_start();
      wait_finish(300);
      check("postrst_buttons", buttons, 32'h0000_F0F0);
      check("postrst_changed", changed, 2'b01);
      check("postrst_lows", low_cnt, 16);
      tick(5);

      // Start coincident with gap expiry
      r0 = rise_cnt;
      lat_hi = 0;
      fin_cnt = 0;
      auto_poll = 1'b1;
      tick(GAP - 1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("coinc_latch_now", latch, 1);
      tick(10);
      auto_poll = 1'b0;
      wait_finish(300);
      tick(100);
      check("coinc_rises", rise_cnt, r0 + 1);
      check("coinc_latch_width", lat_hi, LC);
      check("coinc_finishes", fin_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
